pdm_speaker_tx: RTL
===================

Name: pdm_speaker_tx

Overview:
Wishbone peripheral that accepts signed PCM samples from the CPU into a small FIFO and drives a first-order sigma-delta PDM bitstream plus bit clock to a speaker or class-D amplifier. It is the transmit counterpart of the PDM microphone path: clock divider out, one data bit per PDM clock. An interrupt requests refill when the FIFO runs low.

Parameters:
WB_HZ, 48000000, system clock frequency in Hz.
PDM_HZ, 3000000, PDM bit clock frequency in Hz; TICKS = WB_HZ/PDM_HZ/2 must be >= 2.
AUDIO_BITS, 16, PCM sample width, signed two's complement.
OSR, 64, PDM bits per PCM sample, power of two.
FIFO_DEPTH, 16, sample FIFO entries, power of two.
LOW_WATER, 4, irq asserts when FIFO level <= this.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wb_stb  input  1  Wishbone strobe (cyc qualified upstream)
wb_we  input  1  write enable
wb_adr  input  2  register word address
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data
wb_ack  output  1  acknowledge
pdm_clk  output  1  PDM bit clock
pdm_data  output  1  PDM bitstream
irq  output  1  low-water interrupt, level

Behaviour:
- Reset: synchronous, active-high, clock clk. Sets wb_ack=0, wb_dat_o=0, pdm_clk=0, pdm_data=0, irq=0, FIFO empty, CTRL=0, sticky flags=0, accumulator=0, divider and OSR counters=0. Mid-operation reset discards FIFO contents and current sample.
- Bus: wb_ack registered, wb_ack <= wb_stb & !wb_ack, i.e. one-cycle ack, 1 cycle latency, no back-to-back ack. Side effects occur only on the cycle wb_ack is set. wb_dat_o is valid with wb_ack and 0 otherwise.
- adr 0 DATA: write pushes wb_dat_i[AUDIO_BITS-1:0]. If the FIFO is full, the write is dropped and OVERFLOW is set. Reads return 0.
- adr 1 STATUS (read): bit0 full, bit1 empty, bit2 UNDERRUN sticky, bit3 OVERFLOW sticky, bits[15:8] level. Write 1 to bit2/bit3 clears that flag. A same-cycle set has priority over the clear.
- adr 2 CTRL (R/W): bit0 EN, bit1 IRQ_EN. adr 3 reads 0, writes ignored.
- Divider: runs only while EN=1. The counter counts 0..TICKS-1. At TICKS-1 it wraps to 0 and pdm_clk toggles. Full bit period = 2*TICKS clk. EN=0: the counter is held at 0, pdm_clk=0, pdm_data=0, accumulator=0, OSR counter=0. The FIFO is preserved.
- Data timing: pdm_data updates only on the clk cycle where pdm_clk toggles 1->0, so it is stable around the rising edge for the receiver.
- Sample fetch: the OSR counter increments per falling edge. When it is 0, the current sample is loaded by popping the FIFO. If the FIFO is empty, the sample is loaded as 0 (mid-scale) and UNDERRUN is set. A push and pop in the same cycle leave the level unchanged. The first falling edge after EN rises fetches.
- Modulator: u = sample with MSB inverted (offset binary, AUDIO_BITS wide). acc is AUDIO_BITS+1 wide. Each falling edge: acc <= {1'b0, acc[AUDIO_BITS-1:0]} + u, and pdm_data <= carry bit of that sum. Ones density = u / 2^AUDIO_BITS.
- irq: registered, irq <= IRQ_EN & EN & (level <= LOW_WATER). It deasserts the cycle after level rises above LOW_WATER.

Test Plan:
- Reset/regs: assert rst mid-stream with FIFO level 5 -> next cycle STATUS reads empty=1, level=0, flags=0; pdm_clk=pdm_data=0; CTRL reads 0.
- Divider: defaults, EN=1 -> pdm_clk period 16 clk, 50% duty. pdm_data changes only on the cycle pdm_clk falls. EN=0 -> pdm_clk low within 1 cycle.
- Modulation: push 0x0000, 0x7FFF, 0x8000 with EN=1 -> 64 bits each of density 0.5 (alternating 1010 after the first bit), then all 1s, then all 0s.
- FIFO bounds: 17 writes with EN=0 -> 17th dropped, full=1, OVERFLOW=1, level=16. Clear OVERFLOW via write 0x8 -> reads 0.
- Underrun: EN=1 with empty FIFO -> UNDERRUN=1 after the first fetch, output density 0.5. Push a sample -> it is used at the next 64-bit boundary.
- irq: IRQ_EN=1, EN=1, level 6 draining -> irq rises 1 cycle after level reaches 4. A push bringing the level to 5 -> irq falls the next cycle.

Source files
------------

// File: rtl/pdm_speaker_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pdm_speaker_tx
//  Purpose  : Wishbone PCM sample FIFO feeding a first-order sigma-delta
//             modulator.  Produces a PDM bit clock and a one-bit-per-clock
//             PDM bitstream for a speaker / class-D amplifier.  A level
//             interrupt requests refill when the FIFO runs low.
//  Ports    : clk, rst        - system clock, synchronous active-high reset
//             wb_*            - Wishbone slave (DATA/STATUS/CTRL registers)
//             pdm_clk         - PDM bit clock
//             pdm_data        - PDM bitstream, changes on pdm_clk falling
//             irq             - low-water interrupt, level
//  Revision : 1.0 - initial release
// ============================================================================
module pdm_speaker_tx #(
    parameter int WB_HZ      = 48000000,
    parameter int PDM_HZ     = 3000000,
    parameter int AUDIO_BITS = 16,
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        pdm_clk,
    output logic        pdm_data,
    output logic        irq
);

    localparam int c_ticks = WB_HZ / PDM_HZ / 2;
    localparam int c_div_w = (c_ticks > 1) ? $clog2(c_ticks) : 1;
    localparam int c_osr_w = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_ticks - 1);
    localparam logic [c_lvl_w-1:0] c_depth    = c_lvl_w'(FIFO_DEPTH);
    localparam logic [31:0]        c_low      = LOW_WATER;

    // ---------------------------------------------------------------- state
    logic                  ack_q,    ack_d;
    logic [31:0]           dat_q,    dat_d;
    logic [1:0]            ctrl_q,   ctrl_d;     // [0] EN, [1] IRQ_EN
    logic                  under_q,  under_d;
    logic                  over_q,   over_d;
    logic [c_div_w-1:0]    div_q,    div_d;
    logic                  pclk_q,   pclk_d;
    logic                  pdata_q,  pdata_d;
    logic [AUDIO_BITS:0]   acc_q,    acc_d;
    logic [c_osr_w-1:0]    osr_q,    osr_d;
    logic [AUDIO_BITS-1:0] sample_q, sample_d;
    logic [c_ptr_w-1:0]    wr_q,     wr_d;
    logic [c_ptr_w-1:0]    rd_q,     rd_d;
    logic [c_lvl_w-1:0]    level_q,  level_d;
    logic                  irq_q,    irq_d;
    logic [AUDIO_BITS-1:0] mem_q [FIFO_DEPTH];

    // ---------------------------------------------------------- decode
    logic                  w_acc, w_wr, w_rd;
    logic                  w_full, w_empty, w_en;
    logic                  w_tick, w_fall, w_fetch, w_push, w_pop;
    logic [AUDIO_BITS-1:0] w_cur, w_u;
    logic [AUDIO_BITS:0]   w_sum;
    logic [31:0]           w_rdata;

    // Bus side effects happen on the same edge that raises wb_ack.
    assign w_acc   = wb_stb & ~ack_q;
    assign w_wr    = w_acc & wb_we;
    assign w_rd    = w_acc & ~wb_we;
    assign w_full  = (level_q == c_depth);
    assign w_empty = (level_q == '0);
    assign w_en    = ctrl_q[0];

    assign w_tick  = w_en & (div_q == c_div_last);
    assign w_fall  = w_tick & pclk_q;            // pdm_clk 1 -> 0 this edge
    assign w_fetch = w_fall & (osr_q == '0);
    assign w_pop   = w_fetch & ~w_empty;
    assign w_push  = w_wr & (wb_adr == 2'd0) & ~w_full;

    // On a fetch edge the freshly loaded sample is modulated immediately;
    // an empty FIFO substitutes mid-scale (signed zero).
    assign w_cur = w_fetch ? (w_empty ? '0 : mem_q[rd_q]) : sample_q;
    assign w_u   = {~w_cur[AUDIO_BITS-1], w_cur[AUDIO_BITS-2:0]};
    assign w_sum = {1'b0, acc_q[AUDIO_BITS-1:0]} + {1'b0, w_u};

    always_comb begin
        w_rdata = '0;
        case (wb_adr)
            2'd1:    w_rdata = {16'h0, 8'(level_q), 4'h0, over_q, under_q, w_empty, w_full};
            2'd2:    w_rdata = {30'h0, ctrl_q};
            default: w_rdata = '0;
        endcase
    end

    // ---------------------------------------------------------- next state
    always_comb begin
        ack_d    = w_acc;
        dat_d    = w_rd ? w_rdata : 32'h0;
        ctrl_d   = (w_wr && wb_adr == 2'd2) ? wb_dat_i[1:0] : ctrl_q;

        // Clear first, then set, so a same-cycle set wins.
        under_d  = under_q & ~(w_wr && wb_adr == 2'd1 && wb_dat_i[2]);
        over_d   = over_q  & ~(w_wr && wb_adr == 2'd1 && wb_dat_i[3]);
        if (w_fetch && w_empty)
            under_d = 1'b1;
        if (w_wr && wb_adr == 2'd0 && w_full)
            over_d = 1'b1;

        div_d    = div_q;
        pclk_d   = pclk_q;
        pdata_d  = pdata_q;
        acc_d    = acc_q;
        osr_d    = osr_q;
        sample_d = w_fetch ? w_cur : sample_q;

        if (!w_en) begin
            div_d   = '0;
            pclk_d  = 1'b0;
            pdata_d = 1'b0;
            acc_d   = '0;
            osr_d   = '0;
        end else begin
            div_d  = w_tick ? '0 : div_q + c_div_w'(1);
            pclk_d = pclk_q ^ w_tick;
            if (w_fall) begin
                acc_d   = w_sum;
                pdata_d = w_sum[AUDIO_BITS];
                osr_d   = osr_q + c_osr_w'(1);
            end
        end

        wr_d    = wr_q + c_ptr_w'(w_push);
        rd_d    = rd_q + c_ptr_w'(w_pop);
        level_d = level_q + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
        irq_d   = ctrl_q[1] & ctrl_q[0] & (32'(level_q) <= c_low);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            ctrl_q   <= '0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
            div_q    <= '0;
            pclk_q   <= 1'b0;
            pdata_q  <= 1'b0;
            acc_q    <= '0;
            osr_q    <= '0;
            sample_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ctrl_q   <= ctrl_d;
            under_q  <= under_d;
            over_q   <= over_d;
            div_q    <= div_d;
            pclk_q   <= pclk_d;
            pdata_q  <= pdata_d;
            acc_q    <= acc_d;
            osr_q    <= osr_d;
            sample_q <= sample_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            irq_q    <= irq_d;
        end
    end

    // Sample storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            mem_q[wr_q] <= wb_dat_i[AUDIO_BITS-1:0];
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign pdm_clk  = pclk_q;
    assign pdm_data = pdata_q;
    assign irq      = irq_q;

    // Upper write-data bits and the stored carry are intentionally unread.
    logic w_unused;
    assign w_unused = &{1'b0, wb_dat_i[31:AUDIO_BITS], acc_q[AUDIO_BITS]};

endmodule
`default_nettype wire
